// File: rtl/svnet_arb_pkg.sv
// Shared types and helpers for the svnet FIFO write-port arbiter.
// rr_pick is the behavioural reference for the rotate-priority search used by svnet_rr_picker.
package svnet_arb_pkg;

    // Upper bound on requester count handled by rr_pick.
    localparam int RR_MAX_N = 64;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int owner_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set index scanning ptr, ptr+1, ... modulo n; 0 when nothing is set.
    function automatic int rr_pick(input logic [RR_MAX_N-1:0] req, input int ptr, input int n);
        int pick;
        int idx;
        pick = 0;
        for (int k = RR_MAX_N - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/svnet_rr_picker.sv
// Combinational rotate-priority encoder: picks the first requester at or after ptr, wrapping modulo N.
module svnet_rr_picker
    import svnet_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] index
);

    logic [RR_MAX_N-1:0] req_ext;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        index          = PW'(rr_pick(req_ext, int'(ptr), N));
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign onehot[gi] = req[gi] && (index == PW'(gi));
        end
    endgenerate

endmodule

// File: rtl/svnet_fifo_wr_arbiter.sv
// Round-robin arbiter with bounded burst locking sharing one FIFO write port among N producers.
// The write is registered, so space_ok discounts the write already in flight.
module svnet_fifo_wr_arbiter
    import svnet_arb_pkg::*;
#(
    parameter int N         = 2,
    parameter int WIDTH     = 1,
    parameter int DEPTH     = 1,
    parameter int MAX_BURST = 4,
    localparam int FSW      = $clog2(DEPTH) + 1,
    localparam int OW       = owner_width(N),
    localparam int BW       = $clog2(MAX_BURST + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N-1:0]              req,
    input  logic [N-1:0][WIDTH-1:0]   req_data,
    output logic [N-1:0]              gnt,
    input  logic [FSW-1:0]            fifo_free_space,
    output logic                      fifo_write,
    output logic [WIDTH-1:0]          fifo_write_data,
    output logic [OW-1:0]             owner,
    output logic                      locked
);

    arb_state_e         state_q, state_d;
    logic [OW-1:0]      rr_q, rr_d;
    logic [BW-1:0]      burst_q, burst_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic               wr_q, wr_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;

    logic               space_ok;
    logic [N-1:0]       owner_onehot;
    logic [N-1:0]       pick_onehot;
    logic [OW-1:0]      pick_index;
    logic [OW-1:0]      winner;
    logic [BW-1:0]      burst_new;

    function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] x);
        return (int'(x) == N - 1) ? '0 : x + OW'(1);
    endfunction

    // fifo_free_space does not yet include the write landing at this edge.
    assign space_ok = fifo_free_space > FSW'(wr_q);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_owner_onehot
            assign owner_onehot[gi] = (owner_q == OW'(gi));
        end
    endgenerate

    svnet_rr_picker #(
        .N  (N),
        .PW (OW)
    ) u_picker (
        .req    (req),
        .ptr    (rr_q),
        .onehot (pick_onehot),
        .index  (pick_index)
    );

    always_comb begin
        gnt       = '0;
        winner    = pick_index;
        state_d   = state_q;
        rr_d      = rr_q;
        burst_d   = burst_q;
        owner_d   = owner_q;
        wr_d      = 1'b0;
        wdata_d   = wdata_q;
        burst_new = '0;

        if (state_q == ARB_LOCKED) begin
            winner = owner_q;
            if (space_ok && req[owner_q]) begin
                gnt = owner_onehot;
            end
        end else if (space_ok && (|req)) begin
            gnt = pick_onehot;
        end

        if (rst) begin
            gnt = '0;
        end

        if (|gnt) begin
            wr_d      = 1'b1;
            wdata_d   = req_data[winner];
            owner_d   = winner;
            burst_new = (state_q == ARB_LOCKED) ? burst_q + BW'(1) : BW'(1);
            if (int'(burst_new) < MAX_BURST) begin
                state_d = ARB_LOCKED;
                burst_d = burst_new;
            end else begin
                state_d = ARB_OPEN;
                burst_d = '0;
                rr_d    = wrap_inc(winner);
            end
        end else if ((state_q == ARB_LOCKED) && !req[owner_q]) begin
            // Owner went idle mid-burst: hand the port on. A pure space stall keeps the lock.
            state_d = ARB_OPEN;
            burst_d = '0;
            rr_d    = wrap_inc(owner_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_OPEN;
            rr_q    <= '0;
            burst_q <= '0;
            owner_q <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            burst_q <= burst_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
        end
    end

    assign fifo_write      = wr_q;
    assign fifo_write_data = wdata_q;
    assign owner           = owner_q;
    assign locked          = (state_q == ARB_LOCKED);

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_gnt_has_req: assert property (@(posedge clk) disable iff (rst) (gnt & ~req) == '0);
    a_no_full_write: assert property (@(posedge clk) disable iff (rst) fifo_write |-> (fifo_free_space != '0));

endmodule
